// File: rtl/hash_bucket_counter_if.sv
// Read-side port bundle of the hash-key FIFO: head entry, stall indication and pop pulse.
// Handshake: while in_valid=1, in_hash_key is the FIFO head. The consumer takes that entry by
// holding read_next_ptr=1 for exactly one cycle. The head advances at the end of that cycle.
// There is no ready signal; the pop pulse is the only acknowledgement.
interface hash_bucket_counter_if #(
    parameter int unsigned KEY_W = 16
);
    logic             in_valid;
    logic [KEY_W-1:0] in_hash_key;
    logic             upstream_stall;
    logic             read_next_ptr;

    modport master (
        output in_valid,
        output in_hash_key,
        output upstream_stall,
        input  read_next_ptr
    );

    modport slave (
        input  in_valid,
        input  in_hash_key,
        input  upstream_stall,
        output read_next_ptr
    );
endinterface

// File: rtl/hash_bucket_counter.sv
// Pops hash keys from a FIFO and folds each key to a bucket index.
// Keeps a saturating per-bucket occurrence count, statistics and a clear sweep.
module hash_bucket_counter #(
    parameter int unsigned KEY_W         = 16,
    parameter int unsigned BUCKET_ADDR_W = 8,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned STAT_W        = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    hash_bucket_counter_if.slave     fifo,
    input  logic                     clear,
    input  logic [BUCKET_ADDR_W-1:0] sw_addr,
    output logic [CNT_W-1:0]         sw_rdata,
    output logic [STAT_W-1:0]        keys_processed,
    output logic [STAT_W-1:0]        sat_events,
    output logic [STAT_W-1:0]        stall_cycles,
    output logic                     busy,
    output logic [2:0]               dbg_state
);

    localparam int unsigned BUCKETS = 1 << BUCKET_ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_READ    = 3'd2,
        S_WRITE   = 3'd3,
        S_CLEAR   = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic [KEY_W-1:0]         key_q, key_d;
    logic [CNT_W-1:0]         cur_q, cur_d;
    logic [BUCKET_ADDR_W-1:0] ptr_q, ptr_d;
    logic [STAT_W-1:0]        keys_q, keys_d;
    logic [STAT_W-1:0]        sat_q, sat_d;
    logic [STAT_W-1:0]        stall_q, stall_d;
    logic [CNT_W-1:0]         sw_rdata_q;
    logic [CNT_W-1:0]         bucket_q [BUCKETS];

    logic                     mem_we;
    logic [BUCKET_ADDR_W-1:0] mem_waddr;
    logic [CNT_W-1:0]         mem_wdata;
    logic [7:0]               fold;
    logic [BUCKET_ADDR_W-1:0] idx;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

    // XOR of the two key bytes, then truncated or zero-extended to the bucket address width.
    assign fold = key_q[15:8] ^ key_q[7:0];
    assign idx  = BUCKET_ADDR_W'(fold);

    assign fifo.read_next_ptr = (state_q == S_CAPTURE);

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        cur_d     = cur_q;
        ptr_d     = ptr_q;
        keys_d    = keys_q;
        sat_d     = sat_q;
        stall_d   = fifo.upstream_stall ? sat_inc(stall_q) : stall_q;
        mem_we    = 1'b0;
        mem_waddr = idx;
        mem_wdata = '0;

        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end else if (fifo.in_valid) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                key_d   = fifo.in_hash_key;
                state_d = S_READ;
            end
            S_READ: begin
                cur_d   = bucket_q[idx];
                state_d = S_WRITE;
            end
            S_WRITE: begin
                // A saturated bucket is left alone; the attempt is recorded instead.
                if (&cur_q) begin
                    sat_d = sat_inc(sat_q);
                end else begin
                    mem_we    = 1'b1;
                    mem_wdata = cur_q + CNT_W'(1);
                end
                keys_d  = sat_inc(keys_q);
                state_d = S_IDLE;
            end
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
                ptr_d     = ptr_q + BUCKET_ADDR_W'(1);
                if (&ptr_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            key_q      <= '0;
            cur_q      <= '0;
            ptr_q      <= '0;
            keys_q     <= '0;
            sat_q      <= '0;
            stall_q    <= '0;
            sw_rdata_q <= '0;
            for (int i = 0; i < BUCKETS; i++) begin
                bucket_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            cur_q      <= cur_d;
            ptr_q      <= ptr_d;
            keys_q     <= keys_d;
            sat_q      <= sat_d;
            stall_q    <= stall_d;
            // Readback samples the array before this cycle's write lands.
            sw_rdata_q <= bucket_q[sw_addr];
            if (mem_we) begin
                bucket_q[mem_waddr] <= mem_wdata;
            end
        end
    end

    assign sw_rdata       = sw_rdata_q;
    assign keys_processed = keys_q;
    assign sat_events     = sat_q;
    assign stall_cycles   = stall_q;
    assign busy           = (state_q != S_IDLE);
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_hash_bucket_counter.sv
// Bench for hash_bucket_counter: FIFO model feeding random and directed keys, with a
// bucket-histogram reference model and a second instance using a 2-bit count.
module tb_hash_bucket_counter;
  localparam int NB      = 256;
  localparam int CNT_MAX = 65535;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  hash_bucket_counter_if #(.KEY_W(16)) bus ();
  hash_bucket_counter_if #(.KEY_W(16)) bus2 ();

  logic        clear = 1'b0;
  logic [7:0]  sw_addr = '0;
  logic [15:0] sw_rdata;
  logic [31:0] keys_processed, sat_events, stall_cycles;
  logic        busy;
  logic [2:0]  dbg_state;

  logic        clear2 = 1'b0;
  logic [7:0]  sw_addr2 = '0;
  logic [1:0]  sw_rdata2;
  logic [31:0] keys2, sat2, stall2;
  logic        busy2;
  logic [2:0]  dbg_state2;

  hash_bucket_counter dut (
    .clk(clk), .rstn(rstn), .fifo(bus.slave), .clear(clear), .sw_addr(sw_addr),
    .sw_rdata(sw_rdata), .keys_processed(keys_processed), .sat_events(sat_events),
    .stall_cycles(stall_cycles), .busy(busy), .dbg_state(dbg_state)
  );

  hash_bucket_counter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rstn(rstn), .fifo(bus2.slave), .clear(clear2), .sw_addr(sw_addr2),
    .sw_rdata(sw_rdata2), .keys_processed(keys2), .sat_events(sat2),
    .stall_cycles(stall2), .busy(busy2), .dbg_state(dbg_state2)
  );

  // scoreboard / reference model
  int n_cmp = 0;
  int n_err = 0;
  int m_cnt [NB];
  int m_keys = 0;
  int m_sat = 0;
  int m_stall = 0;
  int cyc = 0;
  int n_pops = 0;
  int pop_cyc_q [$];
  logic [15:0] exp_q [$];
  logic [15:0] pend_q [$];
  bit pop_pend = 0;
  bit stall_force = 0;
  bit stall_rand = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [15:0] k);
    int kk;
    kk = int'(k);
    return ((kk >> 8) ^ kk) % NB;
  endfunction

  function automatic void model_count(input logic [15:0] k);
    int b;
    b = idx_of(k);
    if (m_cnt[b] == CNT_MAX) m_sat++;
    else m_cnt[b]++;
    m_keys++;
  endfunction

  function automatic void model_clear_all();
    for (int i = 0; i < NB; i++) m_cnt[i] = 0;
  endfunction

  // clock/cycle counter and stall model
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rstn) m_stall = 0;
      else if (bus.upstream_stall) m_stall++;
    end
  end

  // FIFO model: the head is shown at each negedge; a pop seen during CAPTURE advances it at
  // the next negedge, after the DUT has latched the key.
  initial begin
    bus.in_valid = 1'b0;
    bus.in_hash_key = '0;
    forever begin
      @(negedge clk);
      if (pop_pend && exp_q.size() > 0) void'(exp_q.pop_front());
      while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
      bus.in_valid = (exp_q.size() > 0);
      bus.in_hash_key = (exp_q.size() > 0) ? exp_q[0] : 16'h0;
      pop_pend = bus.read_next_ptr;
      if (pop_pend) begin
        n_pops++;
        pop_cyc_q.push_back(cyc);
        if (exp_q.size() > 0) model_count(exp_q[0]);
        else check("pop_empty_fifo", 1, 0);
      end
    end
  end

  initial begin
    bus.upstream_stall = 1'b0;
    forever begin
      @(negedge clk);
      bus.upstream_stall = stall_force | (stall_rand && ($urandom_range(0, 3) == 0));
    end
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_key(input logic [15:0] k);
    @(posedge clk);
    #1;
    pend_q.push_back(k);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (n < max_cyc) begin
      step();
      n++;
      if (!busy && exp_q.size() == 0 && pend_q.size() == 0) break;
    end
    check("idle_in_time", (n < max_cyc), 1);
  endtask

  task automatic wait_pop();
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus.read_next_ptr) begin
        ok = 1;
        break;
      end
    end
    check("pop_seen", ok, 1);
  endtask

  task automatic sweep(input string tag);
    step();
    sw_addr = 8'd0;
    for (int a = 0; a < NB; a++) begin
      step();
      check($sformatf("%s[%0d]", tag, a), sw_rdata, m_cnt[a]);
      sw_addr = 8'(a + 1);
    end
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_keys"}, keys_processed, m_keys);
    check({tag, "_sat"}, sat_events, m_sat);
    check({tag, "_stall"}, stall_cycles, m_stall);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_rnp, n_busy, guard, pops2;
    logic [15:0] k;
    model_clear_all();
    bus2.in_valid = 1'b0;
    bus2.in_hash_key = '0;
    bus2.upstream_stall = 1'b0;

    // reset and idle behaviour
    rstn = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
    n_rnp = 0;
    n_busy = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.read_next_ptr) n_rnp++;
      if (busy) n_busy++;
    end
    check("idle_pops", n_rnp, 0);
    check("idle_busy", n_busy, 0);
    check("rst_keys", keys_processed, 0);
    check("rst_sat", sat_events, 0);
    check("rst_stall", stall_cycles, 0);
    sweep("rst_bucket");

    // 2-bit counters: five keys into bucket 3
    step();
    bus2.in_valid = 1'b1;
    bus2.in_hash_key = 16'h0003;
    pops2 = 0;
    guard = 0;
    while (pops2 < 5 && guard < 100) begin
      step();
      guard++;
      if (bus2.read_next_ptr) pops2++;
    end
    bus2.in_valid = 1'b0;
    repeat (6) step();
    sw_addr2 = 8'd3;
    step();
    step();
    check("sat_pops", pops2, 5);
    check("sat_bucket3", sw_rdata2, 3);
    check("sat_events", sat2, 2);
    check("sat_keys", keys2, 5);

    // single key: one pop pulse, busy for CAPTURE/READ/WRITE
    push_key(16'h1234);
    n_rnp = 0;
    n_busy = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.read_next_ptr) n_rnp++;
      if (busy) n_busy++;
    end
    check("single_pop_cycles", n_rnp, 1);
    check("single_busy_cycles", n_busy, 3);
    sw_addr = 8'h26;
    step();
    step();
    check("single_bucket26", sw_rdata, 1);
    check("single_keys", keys_processed, 1);

    // back-to-back entries: pops exactly 4 cycles apart
    pop_cyc_q.delete();
    @(posedge clk);
    #1;
    repeat (5) pend_q.push_back(16'hA5A5);
    wait_idle(100);
    check("b2b_pops", pop_cyc_q.size(), 5);
    for (int i = 1; i < pop_cyc_q.size(); i++)
      check($sformatf("b2b_spacing%0d", i), pop_cyc_q[i] - pop_cyc_q[i-1], 4);
    sw_addr = 8'h00;
    step();
    step();
    check("b2b_bucket0", sw_rdata, 5);
    check_stats("b2b");

    // clear during WRITE is ignored
    push_key(16'h0102);
    wait_pop();
    step();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_busy = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (busy) n_busy++;
    end
    check("clr_in_write_busy", n_busy, 0);
    check_stats("clr_in_write");

    // clear in IDLE beats a pending key; the key is counted afterwards
    push_key(16'h0505);
    step();
    clear = 1'b1;
    model_clear_all();
    step();
    clear = 1'b0;
    n_busy = 0;
    n_rnp = n_pops;
    for (int i = 0; i < 400; i++) begin
      if (bus.read_next_ptr) break;
      if (busy) n_busy++;
      step();
    end
    check("clear_busy_cycles", n_busy, 256);
    check("clear_pop_after", n_pops - n_rnp, 1);
    wait_idle(50);
    check_stats("clear");
    sweep("clear_bucket");

    // random keys, random gaps, random stall
    stall_rand = 1;
    for (int b = 0; b < 12; b++) begin
      @(posedge clk);
      #1;
      for (int j = 0; j < int'($urandom_range(1, 5)); j++) begin
        k = 16'($urandom_range(0, 65535));
        if ($urandom_range(0, 1) == 1) k[7:0] = k[15:8] ^ 8'($urandom_range(0, 3));
        pend_q.push_back(k);
      end
      repeat ($urandom_range(0, 8)) step();
    end
    wait_idle(1000);
    stall_rand = 0;
    step();
    check_stats("rand");
    sweep("rand_bucket");

    // reset while a key is in READ: key dropped
    push_key(16'h4321);
    wait_pop();
    n_rnp = n_pops;
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    model_clear_all();
    m_keys = 0;
    m_sat = 0;
    n_busy = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (busy) n_busy++;
    end
    sw_addr = 8'h62;
    step();
    step();
    check("rst_read_bucket62", sw_rdata, 0);
    check("rst_read_keys", keys_processed, 0);
    check("rst_read_busy", n_busy, 0);
    check("rst_read_no_pop", n_pops - n_rnp, 0);

    // upstream_stall held for 7 cycles
    @(posedge clk);
    #1;
    stall_force = 1;
    repeat (7) @(posedge clk);
    #1;
    stall_force = 0;
    step();
    check("stall7", stall_cycles, 7);
    check_stats("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
